call_observer: RTL
==================

# call_observer

Upstream feeder of the shadow-stack monitor. Watches the retiring instruction stream of the mor1kx core and decodes subroutine calls (l.jal, optionally l.jalr) and returns (l.jr r9). It holds each control-flow event until its delay slot has retired, then queues it in a small FIFO. The monitor drains the FIFO over a valid/ready handshake. This decouples pipeline timing from monitor/stack latency and flags lost events explicitly.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- insn_i  input  32  instruction word at retirement
- pc_i  input  32  address of insn_i
- rb_data_i  input  32  rB operand value of insn_i (jump target for l.jr/l.jalr)
- insn_valid_i  input  1  insn_i/pc_i/rb_data_i retire this cycle
- flush_i  input  1  pipeline flush (exception/interrupt entry)
- ev_ready_i  input  1  monitor accepts head event
- ev_valid_o  output  1  FIFO non-empty
- ev_call_o  output  1  head event type: 1 = call, 0 = return
- ev_addr_o  output  32  call: return address (pc+8); return: jump target
- overflow_o  output  1  sticky: an event was dropped because the FIFO was full
- dropped_o  output  1  one-cycle pulse: pending event discarded by flush

## Operation
- Decode (only when insn_valid_i): opcode = insn_i[31:26]
  - 6'h01 l.jal → call, addr = pc_i + 8
  - 6'h12 l.jalr → call, addr = pc_i + 8 (only with macro, see Configuration)
  - 6'h11 l.jr with insn_i[15:11] == 5'd9 → return, addr = rb_data_i
  - anything else → no event
- FSM, 2 states:
  - IDLE: decoded event → latch type/addr, go DSLOT. Non-event → stay.
  - DSLOT: the next insn_valid_i is the delay slot. It is never decoded; it pushes the latched event and returns to IDLE. flush_i in DSLOT discards the latch, pulses dropped_o, returns to IDLE.
- flush_i in IDLE: no effect. flush_i and insn_valid_i in the same cycle: flush wins, instruction ignored.
- Push: a full FIFO without a simultaneous pop drops the event and sets overflow_o. overflow_o stays set until reset.
- Pop: ev_valid_o && ev_ready_i. Simultaneous push and pop while full is legal: no drop, count unchanged.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1. pc_i+8 wraps modulo 2^32.

## Timing
- Reset values: ev_valid_o=0, ev_call_o=0, ev_addr_o=0, overflow_o=0, dropped_o=0; FSM=IDLE; FIFO empty.
- Latency from delay-slot retirement to ev_valid_o=1 is one cycle, when the FIFO was empty.
- ev_call_o/ev_addr_o are stable while ev_valid_o=1 and ev_ready_i=0. They may change only after a pop.
- ev_valid_o does not depend combinationally on ev_ready_i.
- Back-to-back events are accepted at one per two retired instructions.
- Throughput is one pop per cycle.
- Reset mid-operation discards the latched event and the FIFO contents. No dropped_o pulse is produced.

## Configuration
- CALL_OBSERVER_JALR_EN
  - Defined: opcode 6'h12 (l.jalr) decodes as a call.
  - Undefined: l.jalr produces no event. A return through an l.jalr-established frame then shows up downstream as a mismatch, which is intended for jal-only firmware.

## Structure
- Shared package `speculoos_pkg`:
  - opcode constants OPC_JAL, OPC_JALR, OPC_JR
  - LINK_REG = 5'd9, DSLOT_OFFSET = 32'd8
  - FSM state typedef
  - event record typedef {call, addr[31:0]}, reused by monitor
- One sub-module: `ev_fifo`, a synchronous FIFO parameterised by DEPTH and width 33, with full/empty/count outputs. The decode logic and FSM stay in the top module.

## Test plan
- l.jal at pc 0x0000_1000, delay slot retires → ev_valid_o=1 one cycle later; ev_call_o=1, ev_addr_o=0x0000_1008.
- l.jr r9 with rb_data_i=0x0000_1008, then delay slot → return event with addr 0x0000_1008. l.jr r3 → no event.
- l.jal then flush_i before the delay slot → dropped_o pulses once; FIFO stays empty.
- DEPTH=4 with ev_ready_i=0: five calls → four queued, overflow_o=1. Drain → addresses come out in order. overflow_o stays 1.
- FIFO full with push and pop in the same cycle → no drop, count stays 4, overflow_o stays 0.
- l.jalr at 0x2000: with the macro → call, addr 0x2008; without the macro → no event.

Source files
------------

// File: rtl/speculoos_pkg.sv
// speculoos_pkg: shared definitions for the shadow-stack front end.
//   - OR1K opcode constants for call/return decode
//   - link register index and delay-slot return offset
//   - call-observer FSM state type
//   - control-flow event record (also consumed by the monitor)
package speculoos_pkg;

  localparam logic [5:0]  OPC_JAL      = 6'h01;
  localparam logic [5:0]  OPC_JALR     = 6'h12;
  localparam logic [5:0]  OPC_JR       = 6'h11;
  localparam logic [4:0]  LINK_REG     = 5'd9;
  localparam logic [31:0] DSLOT_OFFSET = 32'd8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DSLOT = 1'b1
  } obs_state_e;

  // call=1: addr is the return address; call=0: addr is the jump target.
  typedef struct packed {
    logic        call;
    logic [31:0] addr;
  } cf_event_t;

endpackage

// File: rtl/ev_fifo.sv
// ev_fifo: synchronous FIFO for control-flow events.
// Ports:
//   clk, reset      clock, async active-high reset
//   push_i, data_i  write request/data (ignored when full unless popping)
//   pop_i           read request (ignored when empty)
//   data_o          head entry (undefined when empty)
//   full_o, empty_o, count_o  occupancy status
// DEPTH must be a power of two so pointers wrap for free.
module ev_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/call_observer.sv
// call_observer: decodes calls (l.jal, optionally l.jalr) and returns
// (l.jr r9) from the retiring mor1kx instruction stream, holds each event
// until its delay slot retires, then queues it for the shadow-stack monitor.
// Ports:
//   clk, reset                   clock, async active-high reset
//   insn_i, pc_i, rb_data_i      retiring instruction, its PC, its rB value
//   insn_valid_i, flush_i        retire strobe, pipeline flush
//   ev_ready_i                   monitor accepts the head event
//   ev_valid_o, ev_call_o, ev_addr_o  head event of the queue
//   overflow_o                   sticky: event lost to a full queue
//   dropped_o                    pulse: pending event discarded by flush
// Build option: define CALL_OBSERVER_JALR_EN to decode l.jalr as a call.
module call_observer
  import speculoos_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] insn_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rb_data_i,
  input  logic        insn_valid_i,
  input  logic        flush_i,
  input  logic        ev_ready_i,
  output logic        ev_valid_o,
  output logic        ev_call_o,
  output logic [31:0] ev_addr_o,
  output logic        overflow_o,
  output logic        dropped_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  obs_state_e state_q, state_d;
  cf_event_t  lat_q, lat_d;
  cf_event_t  dec_ev, head;
  logic       dec_hit;
  logic       push, pop, drop_d;
  logic       dropped_q, overflow_q, overflow_d;
  logic       fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;

  // Immediate/other register fields play no part in call/return detection.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{insn_i[25:16], insn_i[10:0]};

  // Decode: pure function of the retiring word, qualified by the FSM.
  always_comb begin
    dec_hit = 1'b0;
    dec_ev  = '0;
    case (insn_i[31:26])
      OPC_JAL: begin
        dec_hit     = 1'b1;
        dec_ev.call = 1'b1;
        dec_ev.addr = pc_i + DSLOT_OFFSET;
      end
`ifdef CALL_OBSERVER_JALR_EN
      OPC_JALR: begin
        dec_hit     = 1'b1;
        dec_ev.call = 1'b1;
        dec_ev.addr = pc_i + DSLOT_OFFSET;
      end
`endif
      OPC_JR: begin
        if (insn_i[15:11] == LINK_REG) begin
          dec_hit     = 1'b1;
          dec_ev.call = 1'b0;
          dec_ev.addr = rb_data_i;
        end
      end
      default: ;
    endcase
  end

  // FSM: flush has priority over a retiring instruction in the same cycle.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    push    = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i && insn_valid_i && dec_hit) begin
          lat_d   = dec_ev;
          state_d = ST_DSLOT;
        end
      end
      ST_DSLOT: begin
        if (flush_i) begin
          drop_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (insn_valid_i) begin
          // Delay slot retires: never decoded, just releases the latch.
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop        = ev_ready_i && !fifo_empty;
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      dropped_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      dropped_q  <= drop_d;
      overflow_q <= overflow_d;
    end
  end

  ev_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cf_event_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (lat_q),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Head fields read as zero while empty so stale RAM never leaks out.
  assign ev_valid_o = (fifo_cnt != '0);
  assign ev_call_o  = ev_valid_o && head.call;
  assign ev_addr_o  = ev_valid_o ? head.addr : 32'h0;
  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;

endmodule
